dot_product_accumulator: RTL and testbench

//   Downstream consumer of the 32x32 Vedic multiplier in the matrix-multiply datapath.

---
 rtl/dot_product_accumulator.sv | 86 ++++++++
 tb/tb_dot_product_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// ----------------------------------------------------------------------------
// dot_product_accumulator
//
// Sums VEC_LEN consecutive accepted unsigned products into one dot-product
// element. Each completed element is held in a one-entry valid/ready output
// register. The product feed is stalled only when the last element of a
// vector arrives while the previous result is still waiting to be taken.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   prod_in    : product from the multiplier (unsigned, PROD_W bits)
//   prod_valid : prod_in is valid this cycle
//   prod_ready : accumulator can take prod_in this cycle (combinational)
//   sum_out    : completed dot-product element (ACC_W bits)
//   sum_valid  : sum_out holds a result that has not been taken yet
//   sum_ready  : downstream takes sum_out this cycle
//   elem_cnt   : products accumulated so far in the current vector
//   overflow   : sticky flag, set when an accumulation carries out of ACC_W
// ----------------------------------------------------------------------------
module dot_product_accumulator #(
    parameter int PROD_W  = 64,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 66,
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  elem_cnt,
    output logic              overflow
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   add_full;
    logic             last;
    logic             accept;
    logic             carry;

    assign last       = (elem_cnt == CNT_W'(VEC_LEN - 1));
    // Only the final element of a vector needs somewhere to land, so only it
    // can be stalled by an unconsumed result.
    assign prod_ready = !(last && sum_valid && !sum_ready);
    assign accept     = prod_valid && prod_ready;

    // One extra bit on the adder exposes the carry out of ACC_W.
    assign add_full   = {1'b0, acc} + {1'b0, ACC_W'(prod_in)};
    assign carry      = add_full[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            elem_cnt  <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // Drain first; a completion in the same cycle overrides it so the
            // output register refills without a bubble.
            if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end

            if (accept) begin
                if (carry) begin
                    overflow <= 1'b1;
                end
                if (last) begin
                    sum_out   <= add_full[ACC_W-1:0];
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    elem_cnt  <= '0;
                end else begin
                    acc      <= add_full[ACC_W-1:0];
                    elem_cnt <= elem_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_dot_product_accumulator
//
// Directed bench for dot_product_accumulator. A default instance (ACC_W=66)
// covers normal accumulation, back-pressure, drain/refill and reset; a second
// instance with ACC_W=64 covers the overflow flag.
// ----------------------------------------------------------------------------
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    logic [63:0] prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [65:0] sum_out;
    logic        sum_valid;
    logic        sum_ready;
    logic [1:0]  elem_cnt;
    logic        overflow;

    logic [63:0] prod_in64;
    logic        prod_valid64;
    logic        prod_ready64;
    logic [63:0] sum_out64;
    logic        sum_valid64;
    logic        sum_ready64;
    logic [1:0]  elem_cnt64;
    logic        overflow64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_product_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .elem_cnt   (elem_cnt),
        .overflow   (overflow)
    );

    dot_product_accumulator #(.ACC_W(64)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .prod_in    (prod_in64),
        .prod_valid (prod_valid64),
        .prod_ready (prod_ready64),
        .sum_out    (sum_out64),
        .sum_valid  (sum_valid64),
        .sum_ready  (sum_ready64),
        .elem_cnt   (elem_cnt64),
        .overflow   (overflow64)
    );

    // Advance one clock and settle past the edge before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [65:0] exp_sum;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          gap;

        rst          = 1'b1;
        prod_in      = '0;
        prod_valid   = 1'b0;
        sum_ready    = 1'b1;
        prod_in64    = '0;
        prod_valid64 = 1'b0;
        sum_ready64  = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_out",   sum_out,   0);
        chk("rst_elem_cnt",  elem_cnt,  0);
        chk("rst_overflow",  overflow,  0);
        rst = 1'b0;
        #1;
        chk("rst_prod_ready", prod_ready, 1);

        // T1: 1+2+3+4 back to back
        prod_valid = 1'b1;
        prod_in = 64'd1; tick();
        prod_in = 64'd2; tick();
        chk("t1_elem_cnt_mid", elem_cnt, 2);
        prod_in = 64'd3; tick();
        prod_in = 64'd4; tick();
        prod_valid = 1'b0;
        chk("t1_sum_valid", sum_valid, 1);
        chk("t1_sum_out",   sum_out,   66'd10);
        chk("t1_elem_cnt",  elem_cnt,  0);
        tick();
        chk("t1_drained",   sum_valid, 0);
        chk("t1_sum_hold",  sum_out,   66'd10);

        // T2: four maximal 32x32 products
        prod_valid = 1'b1;
        prod_in = 64'hFFFF_FFFE_0000_0001;
        repeat (4) tick();
        prod_valid = 1'b0;
        chk("t2_sum_valid", sum_valid, 1);
        chk("t2_sum_out",   sum_out,   66'h3_FFFF_FFF8_0000_0004);
        chk("t2_overflow",  overflow,  0);
        tick();

        // T3: stall on the final element only, then drain+refill in one cycle
        sum_ready  = 1'b0;
        prod_valid = 1'b1;
        prod_in = 64'd5;
        repeat (4) tick();
        chk("t3_first_valid", sum_valid, 1);
        chk("t3_first_sum",   sum_out,   66'd20);
        prod_in = 64'd1;
        repeat (3) tick();
        chk("t3_accum_free",  elem_cnt,  3);
        chk("t3_ready_low",   prod_ready, 0);
        tick();
        chk("t3_stall_ready", prod_ready, 0);
        chk("t3_stall_cnt",   elem_cnt,  3);
        chk("t3_stall_sum",   sum_out,   66'd20);
        chk("t3_stall_valid", sum_valid, 1);
        sum_ready = 1'b1;
        #1;
        chk("t3_ready_high",  prod_ready, 1);
        tick();
        prod_valid = 1'b0;
        chk("t3_refill_valid", sum_valid, 1);
        chk("t3_refill_sum",   sum_out,   66'd4);
        tick();
        chk("t3_drained",      sum_valid, 0);

        // T4: previous result taken in the same cycle the next one completes
        sum_ready  = 1'b0;
        prod_valid = 1'b1;
        prod_in = 64'd1; tick();
        prod_in = 64'd2; tick();
        prod_in = 64'd3; tick();
        prod_in = 64'd4; tick();
        prod_in = 64'd10;
        repeat (3) tick();
        chk("t4_held_sum",   sum_out,   66'd10);
        sum_ready = 1'b1;
        tick();
        prod_valid = 1'b0;
        sum_ready  = 1'b0;
        chk("t4_swap_valid", sum_valid, 1);
        chk("t4_swap_sum",   sum_out,   66'd40);
        tick();
        chk("t4_hold_valid", sum_valid, 1);
        chk("t4_hold_sum",   sum_out,   66'd40);
        sum_ready = 1'b1;
        tick();
        chk("t4_drained",    sum_valid, 0);

        // T5: reset mid-vector discards the partial sum
        prod_valid = 1'b1;
        prod_in = 64'd7; tick();
        prod_in = 64'd9; tick();
        prod_valid = 1'b0;
        chk("t5_partial_cnt", elem_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_cnt",   elem_cnt,  0);
        chk("t5_rst_valid", sum_valid, 0);
        prod_valid = 1'b1;
        prod_in = 64'd1;
        repeat (4) tick();
        prod_valid = 1'b0;
        chk("t5_sum_valid", sum_valid, 1);
        chk("t5_sum_out",   sum_out,   66'd4);
        tick();

        // Random a*b products with random idle gaps carrying junk data
        for (int v = 0; v < 3; v++) begin
            exp_sum = '0;
            for (int k = 0; k < 4; k++) begin
                a = $urandom;
                b = $urandom;
                p = 64'(a) * 64'(b);
                exp_sum = exp_sum + 66'(p);
                gap = $urandom_range(0, 3);
                prod_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    prod_in = {$urandom, $urandom};
                    tick();
                end
                prod_valid = 1'b1;
                prod_in = p;
                tick();
            end
            prod_valid = 1'b0;
            chk("gap_sum_valid", sum_valid, 1);
            chk("gap_sum_out",   sum_out,   exp_sum);
            tick();
        end
        chk("gap_overflow", overflow, 0);

        // T6: 64-bit accumulator wraps and flags overflow
        prod_valid64 = 1'b1;
        prod_in64 = 64'h8000_0000_0000_0000; tick();
        prod_in64 = 64'h8000_0000_0000_0000; tick();
        prod_in64 = 64'd0; tick();
        prod_in64 = 64'd0; tick();
        prod_valid64 = 1'b0;
        chk("t6_sum_valid", sum_valid64, 1);
        chk("t6_sum_out",   sum_out64,   0);
        chk("t6_overflow",  overflow64,  1);
        repeat (3) tick();
        chk("t6_sticky",    overflow64,  1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_clear", overflow64,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
